// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter that shares one registered nibble channel
// among four requesters, with a valid/ready output and an optional burst lock.
module rr_mux_arbiter #(
  parameter int unsigned BURST_LEN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [3:0] ack,
  output logic [1:0] sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic [1:0] out_src,
  output logic [7:0] xfer_cnt
);

  localparam int unsigned BW = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0] BurstMax = BW'(BURST_LEN);

  logic [1:0]    owner_q, owner_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          out_valid_q, out_valid_d;
  logic [3:0]    out_data_q, out_data_d;
  logic [1:0]    out_src_q, out_src_d;
  logic [7:0]    xfer_cnt_q, xfer_cnt_d;

  logic       load;
  logic       lock;
  logic       capture;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic [3:0] mux_data;

  assign load    = !out_valid_q || out_ready;
  assign lock    = (bcnt_q < BurstMax) && req[owner_q];
  assign capture = load && (|req) && !rst;

  // Scan starts just past the last winner so the previous owner is considered last.
  always_comb begin
    win   = owner_q;
    found = 1'b0;
    idx   = owner_q;
    for (int k = 1; k <= 4; k++) begin
      idx = owner_q + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    if (lock) begin
      win = owner_q;
    end
  end

  always_comb begin
    mux_data = d0;
    case (win)
      2'd0:    mux_data = d0;
      2'd1:    mux_data = d1;
      2'd2:    mux_data = d2;
      default: mux_data = d3;
    endcase
  end

  assign ack = capture ? (4'b0001 << win) : 4'b0000;
  assign sel = capture ? win : 2'd0;

  always_comb begin
    owner_d     = owner_q;
    bcnt_d      = bcnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (capture) begin
      out_data_d  = mux_data;
      out_src_d   = win;
      out_valid_d = 1'b1;
      if (lock) begin
        bcnt_d = bcnt_q + BW'(1);
      end else begin
        owner_d = win;
        bcnt_d  = BW'(1);
      end
    end else if (load) begin
      out_valid_d = 1'b0;
    end
    if (out_valid_q && out_ready) begin
      xfer_cnt_d = xfer_cnt_q + 8'd1;
    end
  end

  // Reset parks the owner on 3 with the burst exhausted so the first scan begins at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= 2'd3;
      bcnt_q      <= BurstMax;
      out_valid_q <= 1'b0;
      out_data_q  <= 4'd0;
      out_src_q   <= 2'd0;
      xfer_cnt_q  <= 8'd0;
    end else begin
      owner_q     <= owner_d;
      bcnt_q      <= bcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule
